sensor_timing_gen: RTL and testbench
====================================

SENSOR_TIMING_GEN -- requirements
Module: sensor_timing_gen

Interface
REQ-001 SHALL have parameter SENSOR_DAT_WIDTH, default 10, pixel width per channel.
REQ-002 SHALL have parameter CHANNEL_NUM, default 4, pixels output per clock.
REQ-003 SHALL have parameter REG_WD, default 32, width of timing-register inputs.
REQ-004 SHALL have parameter FVAL_LVAL_GAP, default 3, clocks between fval edge and nearest lval edge.
REQ-005 SHALL use a single clock and an asynchronous, active-low reset: clk_sensor_pix in 1, pixel clock; reset_sensor_n in 1, async active-low reset.
REQ-006 i_enable in 1: run request, level.
REQ-007 iv_line_width in REG_WD: active clocks per line.
REQ-008 iv_line_num in REG_WD: lines per frame.
REQ-009 iv_hblank in REG_WD: lval-low clocks between lines.
REQ-010 iv_vblank in REG_WD: fval-low clocks between frames.
REQ-011 iv_pattern_sel in 2: 0 pixel ramp, 1 line count, 2 frame count, 3 reserved (as 0).
REQ-012 o_fval out 1: frame valid, registered.
REQ-013 o_lval out 1: line valid, registered.
REQ-014 ov_pix_data out SENSOR_DAT_WIDTH*CHANNEL_NUM: channel k in bits [k*W +: W], registered.
REQ-015 o_frame_done out 1: one-clock pulse coincident with fval falling.
REQ-016 ov_frame_cnt out 16: completed-frame count.

Function
REQ-017 SHALL implement states IDLE, FV_LEAD, ACTIVE, HBLANK, FV_TRAIL, VBLANK.
REQ-018 SHALL latch all iv_* and iv_pattern_sel into shadow registers at each frame start (leaving IDLE or VBLANK); changes mid-frame SHALL not affect the current frame.
REQ-019 IDLE: fval=lval=0; go to FV_LEAD at the edge sampling i_enable=1 with line_width!=0 and line_num!=0; o_fval=1 from that edge.
REQ-020 FV_LEAD: FVAL_LVAL_GAP clocks of fval=1, lval=0, then ACTIVE.
REQ-021 ACTIVE: exactly line_width clocks of lval=1; then HBLANK if lines remain, else FV_TRAIL.
REQ-022 HBLANK: max(hblank,1) clocks of fval=1, lval=0, then ACTIVE.
REQ-023 FV_TRAIL: FVAL_LVAL_GAP clocks of fval=1, lval=0; then fval=0, o_frame_done pulse, ov_frame_cnt+1 (wraps 0xFFFF->0), enter VBLANK.
REQ-024 VBLANK: max(vblank,1) clocks fval=0; then FV_LEAD if i_enable=1 and parameters valid, else IDLE.
REQ-025 fval-high clocks per frame SHALL equal 2*GAP + N*W + (N-1)*H'; period adds V' (H',V' clamped >=1).
REQ-026 i_enable deassert mid-frame SHALL complete the current frame, then IDLE; no truncated frames or lines.
REQ-027 Zero line_width or line_num at a frame-start check SHALL keep the block in IDLE/VBLANK-exit re-checking every clock, no fval.
REQ-028 Pattern 0: channel k = (pix_cnt*CHANNEL_NUM + k) mod 2^W, pix_cnt restarts at 0 each line.
REQ-029 Pattern 1: all channels = line index (0-based) mod 2^W; pattern 2: all channels = ov_frame_cnt mod 2^W.
REQ-030 ov_pix_data SHALL be 0 whenever o_lval=0.
REQ-031 Internal counters SHALL be REG_WD wide; no overflow for any in-range input.

Reset
REQ-032 reset_sensor_n=0 SHALL immediately force IDLE, o_fval=0, o_lval=0, ov_pix_data=0, o_frame_done=0, ov_frame_cnt=0, shadows=0.
REQ-033 Reset mid-frame SHALL abort the frame without o_frame_done; after release, restart only per REQ-019.

Verification
REQ-034 W=4,N=2,H=2,V=3,GAP=3, enable held -> fval high 16 clocks, low 3, period 19; lval high 4, low 2, high 4.
REQ-035 Pattern 0, CHANNEL_NUM=4, W=4 -> each line clocks show ch0..3 = 0-3, 4-7, 8-11, 12-15; zero in hblank.
REQ-036 Enable dropped at 2nd lval of frame 1 -> frame 1 completes, ov_frame_cnt=1, then IDLE, no further fval.
REQ-037 iv_line_width 4->8 changed mid-frame -> current frame keeps 4-clock lines, next frame 8-clock lines.
REQ-038 H=0,V=0 -> behave as H=1,V=1; line_num=0 -> no fval ever.
REQ-039 Reset asserted during ACTIVE -> all outputs 0 same instant, o_frame_done never pulses, ov_frame_cnt=0.

Source files
------------

// File: rtl/sensor_timing_gen.sv
// Synthetic image-sensor timing generator: fval/lval framing with a selectable
// multi-channel test pattern; frame geometry is shadowed at every frame start.
module sensor_timing_gen #(
  parameter int SENSOR_DAT_WIDTH = 10,
  parameter int CHANNEL_NUM      = 4,
  parameter int REG_WD           = 32,
  parameter int FVAL_LVAL_GAP    = 3
) (
  input  logic                                  clk_sensor_pix,
  input  logic                                  reset_sensor_n,
  input  logic                                  i_enable,
  input  logic [REG_WD-1:0]                     iv_line_width,
  input  logic [REG_WD-1:0]                     iv_line_num,
  input  logic [REG_WD-1:0]                     iv_hblank,
  input  logic [REG_WD-1:0]                     iv_vblank,
  input  logic [1:0]                            iv_pattern_sel,
  output logic                                  o_fval,
  output logic                                  o_lval,
  output logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic                                  o_frame_done,
  output logic [15:0]                           ov_frame_cnt
);

  localparam int PW = SENSOR_DAT_WIDTH * CHANNEL_NUM;
  localparam logic [REG_WD-1:0] GAP_LAST = REG_WD'(FVAL_LVAL_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, FV_LEAD, ACTIVE, HBLANK, FV_TRAIL, VBLANK
  } state_t;

  state_t              state, state_nxt;
  logic [REG_WD-1:0]   cnt, cnt_nxt;
  logic [REG_WD-1:0]   line_idx, line_nxt;
  logic [REG_WD-1:0]   width_s, num_s, hblank_s, vblank_s;
  logic [1:0]          pattern_s;
  logic                load;
  logic                start_ok;
  logic [REG_WD-1:0]   hb_last, vb_last;
  logic                fval_nxt, lval_nxt, done_nxt;
  logic [15:0]         frame_cnt_nxt;
  logic [PW-1:0]       pix_nxt;
  logic [REG_WD-1:0]   ramp;

  assign start_ok = i_enable && (iv_line_width != '0) && (iv_line_num != '0);
  // Zero blanking is clamped to a single clock.
  assign hb_last  = (hblank_s == '0) ? '0 : hblank_s - 1'b1;
  assign vb_last  = (vblank_s == '0) ? '0 : vblank_s - 1'b1;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + 1'b1;
    line_nxt      = line_idx;
    load          = 1'b0;
    done_nxt      = 1'b0;
    frame_cnt_nxt = ov_frame_cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start_ok) begin
          state_nxt = FV_LEAD;
          load      = 1'b1;
        end
      end
      FV_LEAD: begin
        if (cnt == GAP_LAST) begin
          state_nxt = ACTIVE;
          cnt_nxt   = '0;
          line_nxt  = '0;
        end
      end
      ACTIVE: begin
        if (cnt == width_s - 1'b1) begin
          cnt_nxt   = '0;
          state_nxt = (line_idx == num_s - 1'b1) ? FV_TRAIL : HBLANK;
        end
      end
      HBLANK: begin
        if (cnt == hb_last) begin
          state_nxt = ACTIVE;
          cnt_nxt   = '0;
          line_nxt  = line_idx + 1'b1;
        end
      end
      FV_TRAIL: begin
        if (cnt == GAP_LAST) begin
          state_nxt     = VBLANK;
          cnt_nxt       = '0;
          done_nxt      = 1'b1;
          frame_cnt_nxt = ov_frame_cnt + 1'b1;
        end
      end
      VBLANK: begin
        if (cnt == vb_last) begin
          cnt_nxt = '0;
          if (start_ok) begin
            state_nxt = FV_LEAD;
            load      = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_comb begin
    fval_nxt = (state_nxt == FV_LEAD) || (state_nxt == ACTIVE) ||
               (state_nxt == HBLANK)  || (state_nxt == FV_TRAIL);
    lval_nxt = (state_nxt == ACTIVE);
    pix_nxt  = '0;
    ramp     = '0;
    if (lval_nxt) begin
      for (int unsigned k = 0; k < CHANNEL_NUM; k++) begin
        ramp = cnt_nxt * REG_WD'(CHANNEL_NUM) + REG_WD'(k);
        case (pattern_s)
          2'd1:    pix_nxt[k*SENSOR_DAT_WIDTH +: SENSOR_DAT_WIDTH] = SENSOR_DAT_WIDTH'(line_nxt);
          2'd2:    pix_nxt[k*SENSOR_DAT_WIDTH +: SENSOR_DAT_WIDTH] = SENSOR_DAT_WIDTH'(ov_frame_cnt);
          default: pix_nxt[k*SENSOR_DAT_WIDTH +: SENSOR_DAT_WIDTH] = SENSOR_DAT_WIDTH'(ramp);
        endcase
      end
    end
  end

  always_ff @(posedge clk_sensor_pix or negedge reset_sensor_n) begin
    if (!reset_sensor_n) begin
      state        <= IDLE;
      cnt          <= '0;
      line_idx     <= '0;
      width_s      <= '0;
      num_s        <= '0;
      hblank_s     <= '0;
      vblank_s     <= '0;
      pattern_s    <= '0;
      o_fval       <= 1'b0;
      o_lval       <= 1'b0;
      ov_pix_data  <= '0;
      o_frame_done <= 1'b0;
      ov_frame_cnt <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      line_idx     <= line_nxt;
      o_fval       <= fval_nxt;
      o_lval       <= lval_nxt;
      ov_pix_data  <= pix_nxt;
      o_frame_done <= done_nxt;
      ov_frame_cnt <= frame_cnt_nxt;
      if (load) begin
        width_s   <= iv_line_width;
        num_s     <= iv_line_num;
        hblank_s  <= iv_hblank;
        vblank_s  <= iv_vblank;
        pattern_s <= iv_pattern_sel;
      end
    end
  end

endmodule

// File: tb/tb_sensor_timing_gen.sv
// Directed bench for sensor_timing_gen: frame/line timing, patterns, shadowing,
// enable drop, zero-parameter handling and asynchronous reset.
module tb_sensor_timing_gen;

  localparam int W  = 10;
  localparam int CH = 4;
  localparam int RW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [RW-1:0]     line_width, line_num, hblank, vblank;
  logic [1:0]        pattern_sel;
  logic              fval, lval, frame_done;
  logic [W*CH-1:0]   pix_data;
  logic [15:0]       frame_cnt;

  int total = 0;
  int bad   = 0;

  logic            fv [0:63];
  logic            lv [0:63];
  logic            dn [0:63];
  logic [W*CH-1:0] px [0:63];

  always #5 clk = ~clk;

  sensor_timing_gen #(
    .SENSOR_DAT_WIDTH(W),
    .CHANNEL_NUM(CH),
    .REG_WD(RW),
    .FVAL_LVAL_GAP(3)
  ) dut (
    .clk_sensor_pix(clk),
    .reset_sensor_n(rst_n),
    .i_enable(enable),
    .iv_line_width(line_width),
    .iv_line_num(line_num),
    .iv_hblank(hblank),
    .iv_vblank(vblank),
    .iv_pattern_sel(pattern_sel),
    .o_fval(fval),
    .o_lval(lval),
    .ov_pix_data(pix_data),
    .o_frame_done(frame_done),
    .ov_frame_cnt(frame_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W*CH-1:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {W'(c3), W'(c2), W'(c1), W'(c0)};
  endfunction

  function automatic logic [63:0] fv_vec(input int s, input int n);
    logic [63:0] v = '0;
    for (int i = s; i < s + n; i++) v = {v[62:0], fv[i]};
    return v;
  endfunction

  function automatic logic [63:0] lv_vec(input int s, input int n);
    logic [63:0] v = '0;
    for (int i = s; i < s + n; i++) v = {v[62:0], lv[i]};
    return v;
  endfunction

  function automatic logic [63:0] dn_vec(input int s, input int n);
    logic [63:0] v = '0;
    for (int i = s; i < s + n; i++) v = {v[62:0], dn[i]};
    return v;
  endfunction

  function automatic int ones(input int which, input int s, input int n);
    int c = 0;
    for (int i = s; i < s + n; i++)
      c += (which == 0) ? int'(fv[i]) : (which == 1) ? int'(lv[i]) : int'(dn[i]);
    return c;
  endfunction

  // Samples n negedges; optionally drops enable or changes line width after a sample.
  task automatic capture(input int n, input int drop_at, input int chg_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fv[i] = fval;
      lv[i] = lval;
      dn[i] = frame_done;
      px[i] = pix_data;
      if (i == drop_at) enable = 1'b0;
      if (i == chg_at) line_width = 8;
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic setup(input int w, input int n, input int h, input int v, input int pat);
    line_width  = w;
    line_num    = n;
    hblank      = h;
    vblank      = v;
    pattern_sel = 2'(pat);
    enable      = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0;
    line_width = '0; line_num = '0; hblank = '0; vblank = '0; pattern_sel = '0;
    #12;
    check("rst_fval", fval, 0);
    check("rst_lval", lval, 0);
    check("rst_pix", pix_data, 0);
    check("rst_done", frame_done, 0);
    check("rst_fcnt", frame_cnt, 0);

    // Basic timing and ramp pattern, enable held for two frames
    do_reset();
    setup(4, 2, 2, 3, 0);
    capture(38, -1, -1);
    enable = 1'b0;
    check("a_fval_p1", fv_vec(0, 19), 64'(19'b1111111111111111000));
    check("a_lval_p1", lv_vec(0, 19), 64'(19'b0001111001111000000));
    check("a_done_p1", dn_vec(0, 19), 64'(19'b0000000000000000100));
    check("a_fval_p2", fv_vec(19, 19), 64'(19'b1111111111111111000));
    check("a_lval_p2", lv_vec(19, 19), 64'(19'b0001111001111000000));
    check("a_pix_s3", px[3], pk(0, 1, 2, 3));
    check("a_pix_s4", px[4], pk(4, 5, 6, 7));
    check("a_pix_s5", px[5], pk(8, 9, 10, 11));
    check("a_pix_s6", px[6], pk(12, 13, 14, 15));
    check("a_pix_hbl", px[7], 0);
    check("a_pix_l2s0", px[9], pk(0, 1, 2, 3));
    check("a_pix_l2s3", px[12], pk(12, 13, 14, 15));
    check("a_fcnt", frame_cnt, 2);

    // Enable dropped at second line of frame 1, line-count pattern
    do_reset();
    setup(4, 2, 2, 3, 1);
    capture(40, 9, -1);
    check("b_fval_p1", fv_vec(0, 19), 64'(19'b1111111111111111000));
    check("b_fval_after", ones(0, 19, 21), 0);
    check("b_pix_l0", px[6], pk(0, 0, 0, 0));
    check("b_pix_l1", px[9], pk(1, 1, 1, 1));
    check("b_fcnt", frame_cnt, 1);

    // Width change mid-frame takes effect next frame, frame-count pattern
    do_reset();
    setup(4, 2, 2, 3, 2);
    capture(50, 30, 5);
    check("c_lval_f1", ones(1, 0, 19), 8);
    check("c_lval_f2", ones(1, 19, 31), 16);
    check("c_fval_f2", ones(0, 19, 31), 24);
    check("c_pix_f2", px[22], pk(1, 1, 1, 1));
    check("c_fcnt", frame_cnt, 2);

    // Zero blanking clamps to one clock
    do_reset();
    setup(2, 2, 0, 0, 0);
    capture(24, 23, -1);
    check("d_fval_p1", fv_vec(0, 12), 64'(12'b111111111110));
    check("d_lval_p1", lv_vec(0, 12), 64'(12'b000110110000));
    check("d_done_p1", dn_vec(0, 12), 64'(12'b000000000001));
    check("d_fval_p2", fv_vec(12, 12), 64'(12'b111111111110));
    check("d_pix_s4", px[4], pk(4, 5, 6, 7));
    check("d_pix_hbl", px[5], 0);

    // Zero line count never starts a frame
    do_reset();
    setup(4, 0, 2, 3, 0);
    capture(20, -1, -1);
    check("e_no_fval", ones(0, 0, 20), 0);
    enable = 1'b0;

    // Asynchronous reset in the middle of a line
    do_reset();
    setup(4, 2, 2, 3, 0);
    capture(5, -1, -1);
    check("f_pre_lval", lv[4], 1);
    #2 rst_n = 1'b0;
    #1;
    check("f_rst_fval", fval, 0);
    check("f_rst_lval", lval, 0);
    check("f_rst_pix", pix_data, 0);
    check("f_rst_fcnt", frame_cnt, 0);
    capture(4, 0, -1);
    check("f_hold_done", ones(2, 0, 4), 0);
    rst_n = 1'b1;
    capture(20, -1, -1);
    check("f_post_fval", ones(0, 0, 20), 0);
    check("f_post_done", ones(2, 0, 20), 0);
    check("f_post_fcnt", frame_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
